// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller blocks: register offsets,
// register bit positions, the CTRL register layout and a small helper.
package uart_pkg;

  // Register select values taken from bus_addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int STAT_NEMPTY_BIT = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_OVF_BIT    = 2;

  // CTRL bit positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQEN_BIT  = 1;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_FLUSH_BIT  = 31;

  // Stored CTRL fields; flush is a strobe and is never stored
  typedef struct packed {
    logic [7:0] thresh;
    logic       irq_en;
    logic       en;
  } ctrl_reg_t;

  // Clamp a fill level into the 8-bit STATUS count field
  function automatic logic [7:0] sat_byte(input logic [31:0] value);
    return (value > 32'd255) ? 8'hFF : value[7:0];
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with push, pop and flush. Push is accepted when there is
// room or when a pop frees a slot in the same cycle; flush empties the FIFO
// and overrides any same-cycle push or pop.
module uart_fifo #(
  parameter int Depth = 128,
  parameter int Width = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [Width-1:0]             wdata,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic [$clog2(Depth+1)-1:0]   count_next,
  output logic                         push_accept
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_accept;

  assign empty = (count == '0);
  assign full  = (count == CW'(Depth));
  assign rdata = mem[rd_ptr];

  // Decide which operations actually take effect this cycle
  always_comb begin
    pop_accept  = pop && !empty && !flush;
    push_accept = push && !flush && (!full || pop_accept);
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(push_accept) - CW'(pop_accept);
    end
  end

  // Pointer and occupancy state; pointers wrap naturally at Depth
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop_accept)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Storage array, written only for accepted pushes
  always_ff @(posedge clk) begin
    if (push_accept) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped receive controller: buffers bytes from the UART receiver in
// a FIFO, exposes DATA/STATUS/CTRL registers with a one-cycle bus response,
// tracks overrun and drives a threshold-based level interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int Depth     = 128,
  parameter int ThreshRst = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        irq
);

  localparam int CW = $clog2(Depth+1);

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_ctrl: Depth must be a power of two and at least 2");
  end
  if (ThreshRst < 1 || ThreshRst > Depth || ThreshRst > 255) begin : g_bad_thresh
    $error("uart_rx_ctrl: ThreshRst must lie in 1..Depth");
  end

  ctrl_reg_t      ctrl;
  logic           ovf;
  logic [1:0]     reg_sel;
  logic           rd_req;
  logic           wr_req;
  logic           pop;
  logic           flush;
  logic           push;
  logic           push_accept;
  logic           ovf_set;
  logic           ovf_clr;
  logic [7:0]     head_byte;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic [31:0]    rdata_next;
  logic           irq_next;
  logic           unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[30:16], bus_wdata[7:3]};

  assign reg_sel = bus_addr[3:2];
  assign rd_req  = bus_req && !bus_we;
  assign wr_req  = bus_req && bus_we;
  assign pop     = rd_req && (reg_sel == REG_DATA);
  assign flush   = wr_req && (reg_sel == REG_CTRL) && bus_wdata[CTRL_FLUSH_BIT];
  assign push    = rx_valid && ctrl.en;
  // A byte dropped because of a flush is not an overrun
  assign ovf_set = push && !flush && !push_accept;
  assign ovf_clr = wr_req && (reg_sel == REG_STATUS) && bus_wdata[STAT_OVF_BIT];

  uart_fifo #(.Depth(Depth), .Width(8)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .wdata       (rx_byte),
    .rdata       (head_byte),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .count_next  (count_next),
    .push_accept (push_accept)
  );

  // Read-data mux; writes and unmapped reads return zero
  always_comb begin
    rdata_next = '0;
    if (rd_req) begin
      case (reg_sel)
        REG_DATA: begin
          if (!empty) rdata_next = {23'b0, 1'b1, head_byte};
        end
        REG_STATUS: begin
          rdata_next[15:8]            = sat_byte(32'(count));
          rdata_next[STAT_OVF_BIT]    = ovf;
          rdata_next[STAT_FULL_BIT]   = full;
          rdata_next[STAT_NEMPTY_BIT] = !empty;
        end
        REG_CTRL: begin
          rdata_next[CTRL_THRESH_LSB +: 8] = ctrl.thresh;
          rdata_next[CTRL_IRQEN_BIT]       = ctrl.irq_en;
          rdata_next[CTRL_EN_BIT]          = ctrl.en;
        end
        default: rdata_next = '0;
      endcase
    end
  end

  // Interrupt is based on the fill level after this cycle's push/pop/flush
  assign irq_next = ctrl.irq_en && (ctrl.thresh != 8'd0) &&
                    (32'(count_next) >= 32'(ctrl.thresh));

  // Bus response register and interrupt output
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      bus_ack   <= bus_req;
      bus_rdata <= rdata_next;
      irq       <= irq_next;
    end
  end

  // CTRL register and sticky overrun flag; a same-cycle set beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl.en     <= 1'b1;
      ctrl.irq_en <= 1'b0;
      ctrl.thresh <= 8'(ThreshRst);
      ovf         <= 1'b0;
    end else begin
      if (wr_req && (reg_sel == REG_CTRL)) begin
        ctrl.en     <= bus_wdata[CTRL_EN_BIT];
        ctrl.irq_en <= bus_wdata[CTRL_IRQEN_BIT];
        ctrl.thresh <= bus_wdata[CTRL_THRESH_LSB +: 8];
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
